// File: rtl/redun_mont_loop_pkg.sv
// redun_mont_loop_pkg: shared defaults, FSM encodings and output record for the squaring loop sequencer.
package redun_mont_loop_pkg;
    localparam int DEF_NUM_WRDS  = 64;
    localparam int DEF_WRD_BITS  = 17;
    localparam int DEF_ITER_BITS = 40;
    localparam int DEF_OUT_DEPTH = 4;

    typedef logic [DEF_NUM_WRDS*DEF_WRD_BITS-1:0] redun0_t;

    typedef logic [2:0] loop_state_t;
    localparam loop_state_t ST_IDLE  = 3'd0;
    localparam loop_state_t ST_ISSUE = 3'd1;
    localparam loop_state_t ST_WAIT  = 3'd2;
    localparam loop_state_t ST_EMIT  = 3'd3;
    localparam loop_state_t ST_DRAIN = 3'd4;

    typedef struct packed {
        redun0_t                  val;
        logic [DEF_ITER_BITS-1:0] iter;
        logic                     last;
    } loop_out_t;
endpackage

// File: rtl/redun_sync_fifo.sv
// redun_sync_fifo: single-clock first-word-fall-through FIFO with registered count and flags.
module redun_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_q, push, pop;

    // Full comes from the registered count, so a same-cycle pop never frees a slot for a write.
    assign full_o  = cnt_q == FULL_CNT;
    assign empty_o = empty_q;
    assign push    = wr_i && !full_o;
    assign pop     = rd_i && !empty_q;
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
    assign rdata_o = empty_q ? '0 : mem_q[rp_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
        end else begin
            wp_q    <= wp_q + AW'(push);
            rp_q    <= rp_q + AW'(pop);
            cnt_q   <= cnt_d;
            empty_q <= cnt_d == '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/redun_mont_loop.sv
// redun_mont_loop: feeds the squaring engine its own result T times, queueing checkpoints and the final value.
module redun_mont_loop
    import redun_mont_loop_pkg::*;
#(
    parameter int NUM_WRDS  = DEF_NUM_WRDS,
    parameter int WRD_BITS  = DEF_WRD_BITS,
    parameter int ITER_BITS = DEF_ITER_BITS,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [NUM_WRDS*WRD_BITS-1:0] i_sq_in,
    input  logic [ITER_BITS-1:0]         i_iters,
    input  logic [ITER_BITS-1:0]         i_ckpt,
    input  logic                         i_abort,
    output logic                         o_ready,
    output logic [NUM_WRDS*WRD_BITS-1:0] o_eng_sq,
    output logic                         o_eng_val,
    input  logic [NUM_WRDS*WRD_BITS-1:0] i_eng_mul,
    input  logic                         i_eng_val,
    output logic [NUM_WRDS*WRD_BITS-1:0] o_sq_out,
    output logic [ITER_BITS-1:0]         o_iter,
    output logic                         o_last,
    output logic                         o_valid,
    input  logic                         i_out_ready
);
    localparam int VW = NUM_WRDS * WRD_BITS;
    localparam int FW = VW + ITER_BITS + 1;

    loop_state_t          st_q, st_d;
    logic [VW-1:0]        x_q, x_d;
    logic [ITER_BITS-1:0] t_q, t_d, c_q, c_d, cnt_q, cnt_d, ck_q, ck_d;
    logic [ITER_BITS-1:0] cnt_inc, ck_inc;
    logic                 fin_q, fin_d, ready_q, eng_val_q;
    logic                 full, empty, wr;
    logic [FW-1:0]        rdata;

    assign cnt_inc   = cnt_q + ITER_BITS'(1);
    assign ck_inc    = ck_q + ITER_BITS'(1);
    assign wr        = st_q == ST_EMIT && !i_abort && !full;
    assign o_ready   = ready_q;
    assign o_eng_val = eng_val_q;
    assign o_eng_sq  = x_q;
    assign o_valid   = !empty;
    assign {o_sq_out, o_iter, o_last} = rdata;

    always_comb begin
        st_d  = st_q;
        x_d   = x_q;
        t_d   = t_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        ck_d  = ck_q;
        fin_d = fin_q;
        case (st_q)
            ST_IDLE: if (i_start && ready_q) begin
                x_d   = i_sq_in;
                t_d   = i_iters;
                c_d   = i_ckpt;
                cnt_d = '0;
                ck_d  = '0;
                fin_d = i_iters == '0;
                st_d  = i_iters == '0 ? ST_EMIT : ST_ISSUE;
            end
            ST_ISSUE: st_d = i_abort ? ST_DRAIN : ST_WAIT;
            // A result coinciding with the abort has already arrived, so there is nothing left to drain.
            ST_WAIT: if (i_abort) begin
                st_d = i_eng_val ? ST_IDLE : ST_DRAIN;
            end else if (i_eng_val) begin
                x_d   = i_eng_mul;
                cnt_d = cnt_inc;
                ck_d  = ck_inc;
                fin_d = cnt_inc == t_q;
                if (cnt_inc == t_q) st_d = ST_EMIT;
                else if (c_q != '0 && ck_inc == c_q) begin
                    ck_d = '0;
                    st_d = ST_EMIT;
                end else st_d = ST_ISSUE;
            end
            ST_EMIT: if (i_abort) st_d = ST_IDLE;
                     else if (!full) st_d = fin_q ? ST_IDLE : ST_ISSUE;
            ST_DRAIN: if (i_eng_val) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st_q      <= ST_IDLE;
            x_q       <= '0;
            t_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            ck_q      <= '0;
            fin_q     <= 1'b0;
            ready_q   <= 1'b0;
            eng_val_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            x_q       <= x_d;
            t_q       <= t_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            ck_q      <= ck_d;
            fin_q     <= fin_d;
            ready_q   <= st_d == ST_IDLE;
            eng_val_q <= st_d == ST_ISSUE;
        end
    end

    redun_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .wr_i    (wr),
        .wdata_i ({x_q, cnt_q, fin_q}),
        .full_o  (full),
        .rd_i    (i_out_ready),
        .rdata_o (rdata),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_redun_mont_loop.sv
// tb_redun_mont_loop: directed and randomized runs against an X+1 engine model and an iteration-list reference.
module tb_redun_mont_loop;
    import redun_mont_loop_pkg::*;

    localparam int VW    = DEF_NUM_WRDS * DEF_WRD_BITS;
    localparam int IB    = DEF_ITER_BITS;
    localparam int DEPTH = 2;

    typedef struct {
        logic [VW-1:0] v;
        logic [IB-1:0] it;
        logic          l;
    } ent_t;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic          eng_val = 1'b0;
    logic [VW-1:0] sq_in = '0, eng_mul = '0, eng_op = '0;
    logic [IB-1:0] iters = '0, ckpt = '0;
    logic          o_ready, o_eng_val, o_last, o_valid;
    logic [VW-1:0] o_eng_sq, o_sq_out;
    logic [IB-1:0] o_iter;

    int   cyc = 0, lat = 4, eng_cnt = 0, stray_cnt = 0, stray_done = 0;
    int   errors = 0, checks = 0, base = 0;
    ent_t got[$];
    ent_t exp_q[$];
    int   pulses[$];

    redun_mont_loop #(
        .NUM_WRDS  (DEF_NUM_WRDS),
        .WRD_BITS  (DEF_WRD_BITS),
        .ITER_BITS (IB),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_sq_in     (sq_in),
        .i_iters     (iters),
        .i_ckpt      (ckpt),
        .i_abort     (abort),
        .o_ready     (o_ready),
        .o_eng_sq    (o_eng_sq),
        .o_eng_val   (o_eng_val),
        .i_eng_mul   (eng_mul),
        .i_eng_val   (eng_val),
        .o_sq_out    (o_sq_out),
        .o_iter      (o_iter),
        .o_last      (o_last),
        .o_valid     (o_valid),
        .i_out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid === 1'b1 && out_ready === 1'b1) got.push_back('{o_sq_out, o_iter, o_last});
        if (o_eng_val === 1'b1) pulses.push_back(cyc);
    end

    // Engine stand-in: answers each operand with operand+1 after lat cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            eng_val = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_val = 1'b1;
                    eng_mul = eng_op + VW'(1);
                end
            end
            if (stray_cnt != stray_done) begin
                stray_done++;
                eng_val = 1'b1;
                eng_mul = '1;
            end
            if (o_eng_val === 1'b1) begin
                eng_op  = o_eng_sq;
                eng_cnt = lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed ..%0h expected ..%0h (low 96 bits)", tag, obs[95:0], exp[95:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_x();
        logic [VW-1:0] x;
        for (int w = 0; w < VW / 32; w++) x[w*32 +: 32] = $urandom;
        return x;
    endfunction

    // Reference: the value after k squarings is x+k; entries at every C-th step and at step T.
    function automatic void model(input logic [VW-1:0] x, input int t, input int c);
        exp_q.delete();
        if (t == 0) exp_q.push_back('{x, '0, 1'b1});
        for (int k = 1; k <= t; k++)
            if (k == t || (c != 0 && k % c == 0)) exp_q.push_back('{x + VW'(k), IB'(k), k == t});
    endfunction

    task automatic do_start(input logic [VW-1:0] x, input int t, input int c, output int k);
        int n = 0;
        while (o_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("ready_before_start", 64'(o_ready), 64'(1));
        model(x, t, c);
        base  = got.size();
        sq_in = x;
        iters = IB'(t);
        ckpt  = IB'(c);
        start = 1'b1;
        tick();
        k     = cyc;
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input bit rnd);
        int n = 0;
        while (!(o_ready === 1'b1 && o_valid === 1'b0) && n < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk({tag, "_done"}, 64'(n < 3000), 64'(1));
        chk({tag, "_count"}, 64'(got.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            chkv($sformatf("%s_val%0d", tag, i), got[base+i].v, exp_q[i].v);
            chk($sformatf("%s_iter%0d", tag, i), 64'(got[base+i].it), 64'(exp_q[i].it));
            chk($sformatf("%s_last%0d", tag, i), 64'(got[base+i].l), 64'(exp_q[i].l));
        end
    endtask

    initial begin
        int k, pb;
        logic [VW-1:0] x;
        tick();
        tick();
        chk("rst_ready", 64'(o_ready), 64'(0));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_eng_val", 64'(o_eng_val), 64'(0));
        chk("rst_iter", 64'(o_iter), 64'(0));
        chk("rst_last", 64'(o_last), 64'(0));
        chkv("rst_sq_out", o_sq_out, '0);
        rst = 1'b0;
        tick();
        chk("rst_ready_after", 64'(o_ready), 64'(1));

        out_ready = 1'b1;
        pb = pulses.size();
        do_start(VW'(5), 3, 0, k);
        finish_run("basic", 1'b0);
        chk("basic_pulses", 64'(pulses.size() - pb), 64'(3));
        if (pulses.size() >= pb + 3) begin
            chk("basic_first_issue", 64'(pulses[pb]), 64'(k));
            chk("basic_gap1", 64'(pulses[pb+1] - pulses[pb]), 64'(5));
            chk("basic_gap2", 64'(pulses[pb+2] - pulses[pb+1]), 64'(5));
        end

        pb = pulses.size();
        do_start(VW'(16'h1234), 0, 0, k);
        chk("t0_ready_low", 64'(o_ready), 64'(0));
        tick();
        chk("t0_ready_back", 64'(o_ready), 64'(1));
        finish_run("t0", 1'b0);
        chk("t0_no_issue", 64'(pulses.size() - pb), 64'(0));

        do_start(rand_x(), 10, 3, k);
        finish_run("ckpt3", 1'b0);

        out_ready = 1'b0;
        do_start(rand_x(), 10, 1, k);
        repeat (40) tick();
        chk("stall_valid", 64'(o_valid), 64'(1));
        chk("stall_head_iter", 64'(o_iter), 64'(1));
        chk("stall_busy", 64'(o_ready), 64'(0));
        pb = pulses.size();
        repeat (20) tick();
        chk("stall_no_issue", 64'(pulses.size() - pb), 64'(0));
        finish_run("stall", 1'b0);

        lat = 4;
        pb  = pulses.size();
        do_start(rand_x(), 5, 0, k);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_drain_busy", 64'(o_ready), 64'(0));
        tick();
        chk("abort_late_result_busy", 64'(o_ready), 64'(0));
        tick();
        chk("abort_ready", 64'(o_ready), 64'(1));
        chk("abort_no_entry", 64'(o_valid), 64'(0));
        chk("abort_one_issue", 64'(pulses.size() - pb), 64'(1));
        do_start('0, 1, 0, k);
        finish_run("after_abort", 1'b0);

        for (int r = 0; r < 6; r++) begin
            lat = $urandom_range(1, 6);
            x   = rand_x();
            do_start(x, $urandom_range(0, 8), $urandom_range(0, 4), k);
            finish_run($sformatf("rnd%0d", r), 1'b1);
        end

        lat       = 4;
        out_ready = 1'b0;
        do_start(rand_x(), 10, 1, k);
        repeat (40) tick();
        chk("mid_rst_queued", 64'(o_valid), 64'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(o_valid), 64'(0));
        chk("mid_rst_eng_val", 64'(o_eng_val), 64'(0));
        rst = 1'b0;
        tick();
        chk("mid_rst_ready", 64'(o_ready), 64'(1));
        out_ready = 1'b1;
        base = got.size();
        stray_cnt++;
        repeat (10) tick();
        chk("stray_no_valid", 64'(o_valid), 64'(0));
        chk("stray_no_entry", 64'(got.size() - base), 64'(0));
        chk("stray_ready", 64'(o_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
